// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles SOF/CMD/LEN/payload/XOR frames from UART bytes.
// Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
   parameter int         MAX_LEN     = 8,
   parameter logic [7:0] SOF         = 8'hAA,
   parameter int         TIMEOUT_CYC = 50000,
   parameter int         LW          = $clog2(MAX_LEN+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rxReady,
   input  logic [7:0]    rxOut,
   input  logic          frameAck,
   input  logic [LW-1:0] rdAddr,
   output logic [7:0]    rdData,
   output logic          frameValid,
   output logic [7:0]    frameCmd,
   output logic [LW-1:0] frameLen,
   output logic          lenErr,
   output logic          chkErr,
   output logic          ovrErr,
   output logic          toErr
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]    MAXB = 8'(MAX_LEN);
   localparam logic [LW-1:0] MAXA = LW'(MAX_LEN);
   localparam logic [LW-1:0] ONE  = LW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK, S_HOLD
   } state_t;

   state_t        state_q, state_d;
   logic          rx_q, acc_q;
   logic [7:0]    byte_q;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    chk_q, chk_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [7:0]    rd_q;
   logic          buf_we;
   logic          to_hit;
   logic [7:0]    buf_q [MAX_LEN];

   // Rising-edge detect on rxReady; byte captured on the rise cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_q   <= 1'b0;
         acc_q  <= 1'b0;
         byte_q <= '0;
      end else begin
         rx_q  <= rxReady;
         acc_q <= rxReady & ~rx_q;
         if (rxReady & ~rx_q) byte_q <= rxOut;
      end
   end

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TOP  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TONE = TW'(1);

   logic [TW-1:0] to_q, to_d;
   logic          busy;

   // Idle-gap counter, only runs while a frame is partially received
   always_comb begin
      busy   = (state_q == S_CMD) || (state_q == S_LEN) ||
               (state_q == S_PAY) || (state_q == S_CHK);
      to_hit = busy && !acc_q && (to_q == TOP);
      to_d   = to_q + TONE;
      if (!busy || acc_q || to_hit) to_d = '0;
   end

   // Timeout counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) to_q <= '0;
      else      to_q <= to_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (to_hit) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:
               if (acc_q && byte_q == SOF) state_d = S_CMD;
            S_CMD:
               if (acc_q) state_d = S_LEN;
            S_LEN:
               if (acc_q) begin
                  if (byte_q > MAXB)      state_d = S_IDLE;
                  else if (byte_q == '0)  state_d = S_CHK;
                  else                    state_d = S_PAY;
               end
            S_PAY:
               if (acc_q && cnt_q == len_q - ONE)
                  state_d = S_CHK;
            S_CHK:
               if (acc_q)
                  state_d = (byte_q == chk_q) ? S_HOLD : S_IDLE;
            S_HOLD:
               if (frameAck) state_d = S_IDLE;
            default:
               state_d = S_IDLE;
         endcase
      end
   end

   // Frame datapath updates on each accepted byte
   always_comb begin
      cmd_d  = cmd_q;
      chk_d  = chk_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      buf_we = 1'b0;
      if (acc_q) begin
         unique case (state_q)
            S_CMD: begin
               cmd_d = byte_q;
               chk_d = byte_q;
            end
            S_LEN: begin
               chk_d = chk_q ^ byte_q;
               len_d = byte_q[LW-1:0];
               cnt_d = '0;
            end
            S_PAY: begin
               chk_d  = chk_q ^ byte_q;
               cnt_d  = cnt_q + ONE;
               buf_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q <= '0;
         chk_q <= '0;
         len_q <= '0;
         cnt_q <= '0;
      end else begin
         cmd_q <= cmd_d;
         chk_q <= chk_d;
         len_q <= len_d;
         cnt_q <= cnt_d;
      end
   end

   // Payload buffer write; contents need no reset
   always_ff @(posedge clk) begin
      if (buf_we) buf_q[cnt_q[IW-1:0]] <= byte_q;
   end

   // Registered read port, out-of-range index reads zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               rd_q <= '0;
      else if (rdAddr < MAXA) rd_q <= buf_q[rdAddr[IW-1:0]];
      else                    rd_q <= '0;
   end

   // Error pulses, mutually exclusive by state
   always_comb begin
      lenErr = 1'b0;
      chkErr = 1'b0;
      ovrErr = 1'b0;
      toErr  = to_hit;
      if (acc_q) begin
         unique case (1'b1)
            state_q == S_LEN:  lenErr = byte_q > MAXB;
            state_q == S_CHK:  chkErr = byte_q != chk_q;
            state_q == S_HOLD: ovrErr = 1'b1;
            default: ;
         endcase
      end
   end

   assign frameValid = (state_q == S_HOLD);
   assign frameCmd   = cmd_q;
   assign frameLen   = len_q;
   assign rdData     = rd_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench for uart_frame_parser.
// Expected events queued by stimulus, popped by a negedge monitor.
module tb_uart_frame_parser;

   localparam int LW = 4;
   localparam int EV_FRM = 0;
   localparam int EV_LEN = 1;
   localparam int EV_CHK = 2;
   localparam int EV_OVR = 3;
   localparam int EV_TO  = 4;
   localparam int EV_RD  = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rxReady = 1'b0;
   logic [7:0]    rxOut = '0;
   logic          frameAck = 1'b0;
   logic [LW-1:0] rdAddr = '0;
   logic [7:0]    rdData;
   logic          frameValid;
   logic [7:0]    frameCmd;
   logic [LW-1:0] frameLen;
   logic          lenErr, chkErr, ovrErr, toErr;

   logic rd_chk = 1'b0;
   logic rd_live = 1'b0;

   typedef struct {
      int         k;
      logic [7:0] a;
      logic [7:0] b;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   uart_frame_parser #(
      .MAX_LEN(8), .SOF(8'hAA), .TIMEOUT_CYC(20)
   ) dut (
      .clk(clk), .rst(rst),
      .rxReady(rxReady), .rxOut(rxOut),
      .frameAck(frameAck), .rdAddr(rdAddr),
      .rdData(rdData), .frameValid(frameValid),
      .frameCmd(frameCmd), .frameLen(frameLen),
      .lenErr(lenErr), .chkErr(chkErr),
      .ovrErr(ovrErr), .toErr(toErr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_live <= rd_chk;

   function automatic void expect_ev(int k, int a, int b);
      ev_t e;
      e.k = k;
      e.a = 8'(a);
      e.b = 8'(b);
      exp_q.push_back(e);
   endfunction

   function automatic void check_ev(int k, int a, int b);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event got k=%0d a=%h b=%h required none",
                  k, a, b);
      end else begin
         e = exp_q.pop_front();
         if (e.k != k || int'(e.a) != a || int'(e.b) != b) begin
            errors++;
            $display("FAIL event got k=%0d a=%h b=%h required k=%0d a=%h b=%h",
                     k, a, b, e.k, e.a, e.b);
         end
      end
   endfunction

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, act, exp);
      end
   endfunction

   // Monitor: turns DUT outputs into events and scores them
   initial begin
      logic fv_prev;
      fv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (frameValid && !fv_prev)
               check_ev(EV_FRM, int'(frameCmd), int'(frameLen));
            if (lenErr) check_ev(EV_LEN, 0, 0);
            if (chkErr) check_ev(EV_CHK, 0, 0);
            if (ovrErr) check_ev(EV_OVR, 0, 0);
            if (toErr)  check_ev(EV_TO, 0, 0);
            if (rd_live) check_ev(EV_RD, int'(rdData), 0);
         end
         fv_prev = frameValid;
      end
   end

   task automatic send(input logic [7:0] b);
      rxOut   = b;
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input int a, input int e);
      rdAddr = LW'(a);
      rd_chk = 1'b1;
      expect_ev(EV_RD, e, 0);
      @(negedge clk);
      rd_chk = 1'b0;
   endtask

   task automatic ack();
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      chk("valid_after_ack", int'(frameValid), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(frameValid), 0);
      chk("rst_cmd", int'(frameCmd), 0);
      chk("rst_len", int'(frameLen), 0);
      chk("rst_rd", int'(rdData), 0);
      chk("rst_err", int'({lenErr, chkErr, ovrErr, toErr}), 0);
      rst = 1'b1;
      @(negedge clk);

      expect_ev(EV_FRM, 8'h10, 3);
      send(8'hAA); send(8'h10); send(8'h03);
      send(8'h01); send(8'h02); send(8'h03);
      send(8'h13);
      rd(0, 8'h01);
      rd(1, 8'h02);
      rd(2, 8'h03);
      rd(8, 8'h00);
      rd(9, 8'h00);
      ack();

      expect_ev(EV_FRM, 8'h22, 0);
      send(8'hAA); send(8'h22); send(8'h00); send(8'h22);
      repeat (3) @(negedge clk);
      chk("zero_hold", int'(frameValid), 1);
      ack();
      expect_ev(EV_FRM, 8'h05, 0);
      send(8'h55); send(8'hAA); send(8'h05);
      send(8'h00); send(8'h05);
      ack();

      expect_ev(EV_CHK, 0, 0);
      send(8'hAA); send(8'h10); send(8'h03);
      send(8'h01); send(8'h02); send(8'h03);
      send(8'hFF);
      chk("chkerr_valid", int'(frameValid), 0);
      expect_ev(EV_FRM, 8'h01, 1);
      send(8'hAA); send(8'h01); send(8'h01);
      send(8'h07); send(8'h07);
      rd(0, 8'h07);
      ack();

      expect_ev(EV_LEN, 0, 0);
      send(8'hAA); send(8'h10); send(8'h09);
      send(8'h10);
      expect_ev(EV_FRM, 8'h44, 0);
      send(8'hAA); send(8'h44); send(8'h00); send(8'h44);
      expect_ev(EV_OVR, 0, 0);
      send(8'h5A);
      chk("ovr_valid", int'(frameValid), 1);
      chk("ovr_cmd", int'(frameCmd), 8'h44);
      chk("ovr_len", int'(frameLen), 0);
      expect_ev(EV_OVR, 0, 0);
      rxOut   = 8'h5A;
      rxReady = 1'b1;
      @(negedge clk);
      rxReady  = 1'b0;
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      chk("ovr_ack_valid", int'(frameValid), 0);

      expect_ev(EV_FRM, 8'h66, 1);
      send(8'hAA); send(8'h66); send(8'h01);
      send(8'h09); send(8'h6E);
      rd(0, 8'h09);
      ack();
      rdAddr = '0;
      send(8'hAA); send(8'h10); send(8'h03); send(8'h01);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_cmd", int'(frameCmd), 0);
      chk("mid_rst_len", int'(frameLen), 0);
      chk("mid_rst_rd", int'(rdData), 0);
      chk("mid_rst_valid", int'(frameValid), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      expect_ev(EV_FRM, 8'h33, 0);
      rxOut   = 8'hAA;
      rxReady = 1'b1;
      repeat (10) @(negedge clk);
      rxReady = 1'b0;
      @(negedge clk);
      send(8'h33); send(8'h00); send(8'h33);
      ack();

`ifdef UART_FRAME_TIMEOUT_EN
      expect_ev(EV_TO, 0, 0);
`else
      expect_ev(EV_FRM, 8'h10, 0);
`endif
      send(8'hAA); send(8'h10);
      repeat (20) @(negedge clk);
      send(8'h00); send(8'h10);
      ack();

      for (int i = 0; i < 40 && exp_q.size() != 0; i++)
         @(negedge clk);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event got none required k=%0d a=%h",
                  e.k, e.a);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Downstream consumer of the UART receive path: takes the received byte stream (rxReady/rxOut) and assembles command frames for the rest of the design.
- Frame format: SOF byte, CMD byte, LEN byte, LEN payload bytes, then an XOR checksum byte.
- A validated frame is held in a payload buffer and presented to the consumer until acknowledged.
- Bad frames (length, checksum, timeout) are flagged and discarded.

Parameters:
- MAX_LEN, 8, maximum payload bytes; the buffer depth.
- SOF, 8'hAA, start-of-frame byte value.
- TIMEOUT_CYC, 50000, inter-byte timeout in clk cycles (only with the optional feature).
- LW, $clog2(MAX_LEN+1), width of the length field and address ports (derived; not to be overridden).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- rxReady  input  1  byte-available level from the UART receiver
- rxOut  input  8  received byte, valid while rxReady=1
- frameAck  input  1  consumer releases the held frame
- rdAddr  input  LW  payload buffer read index
- rdData  output  8  payload byte at rdAddr, registered
- frameValid  output  1  high while a validated frame is held
- frameCmd  output  8  CMD byte of the held frame
- frameLen  output  LW  LEN of the held frame
- lenErr  output  1  1-cycle pulse: LEN > MAX_LEN
- chkErr  output  1  1-cycle pulse: checksum mismatch
- ovrErr  output  1  1-cycle pulse: byte dropped while holding a frame
- toErr  output  1  1-cycle pulse: inter-byte timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0; rdData=0.
  - Checksum accumulator, byte counter and rxReady edge register are cleared.
  - Buffer contents are don't-care.
- Byte acceptance:
  - One byte is accepted per 0->1 transition of rxReady (registered edge detect), sampling rxOut in that same cycle.
  - The accept strobe occurs 1 cycle after the rxReady rise.
  - A level held high for many cycles counts as one byte.
- FSM states:
  - IDLE: accepted byte == SOF -> CMD; any other byte is ignored.
  - CMD: store the byte in frameCmd staging; chk = byte; -> LEN.
  - LEN:
    - byte > MAX_LEN -> pulse lenErr, -> IDLE.
    - byte == 0 -> CHK.
    - otherwise -> PAYLOAD.
    - In all cases chk ^= byte and the byte is stored as the length.
  - PAYLOAD: buf[cnt] = byte; chk ^= byte; cnt++; when cnt reaches LEN-1 on the write -> CHK.
  - CHK:
    - byte == chk -> HOLD; frameValid rises the next cycle.
    - Otherwise pulse chkErr and -> IDLE.
  - HOLD:
    - frameValid=1; frameCmd and frameLen stable.
    - Any accepted byte is dropped with an ovrErr pulse.
    - frameAck=1 -> IDLE; frameValid=0 the next cycle.
- frameAck outside HOLD is ignored.
- If an accept and frameAck occur in the same HOLD cycle, the byte is dropped (ovrErr) and the ack is honoured.
- Error pulses each last exactly 1 cycle and never assert in the same cycle as each other.
- Read port:
  - rdData <= buf[rdAddr] every cycle (1-cycle latency), in all states.
  - rdAddr >= MAX_LEN returns 0.
  - Buffer contents are stable only while frameValid=1.
- A SOF value appearing inside a frame is ordinary data; there is no resynchronisation except via error or timeout.
- Arithmetic: chk is 8-bit XOR; cnt wraps never, because LEN <= MAX_LEN is enforced.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - A counter clears on each accepted byte and increments each cycle in CMD, LEN, PAYLOAD and CHK.
  - On reaching TIMEOUT_CYC-1: pulse toErr, return to IDLE, clear the counter.
  - Counter is held at 0 in IDLE and HOLD.
- Not defined: no counter logic; toErr tied to 0; a partial frame waits indefinitely.

Test Plan:
- Bytes AA 10 03 01 02 03 13 -> frameValid=1, frameCmd=8'h10, frameLen=3; rdAddr 0,1,2 gives 01,02,03 one cycle later; frameAck -> frameValid=0 next cycle.
- Bytes AA 22 00 22 -> valid zero-length frame, frameCmd=8'h22, frameLen=0; then 55 AA 05 00 05 -> leading 55 ignored, second frame valid only after ack of the first.
- Bytes AA 10 03 01 02 03 FF -> chkErr single pulse, frameValid stays 0; next frame AA 01 01 07 07 accepted.
- Bytes AA 10 09 (MAX_LEN=8) -> lenErr pulse, FSM in IDLE; next byte 10 ignored.
- Frame held without ack, then byte 5A -> ovrErr pulse, frame outputs unchanged; rst=0 mid-PAYLOAD -> all outputs 0 immediately; rxReady held high 10 cycles -> one byte counted.
- With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYC=20: AA 10 then 20 idle cycles -> toErr pulse once, FSM in IDLE. Without the macro, same stimulus -> no toErr, and a later 00 10 completes the frame.
